microgreen_classifier: RTL and testbench
========================================

Name: microgreen_classifier

Overview:
- Tiny Tapeout tile top that classifies a microgreen tray from three 8-bit sensor features: green intensity, red intensity and canopy height in mm.
- Features are loaded one per strobe over ui_in/uio_in; a classify command evaluates a fixed priority rule set.
- Outputs are a registered 3-bit class code, a result-valid flag, a harvest-ready flag and feature-loaded flags on uo_out.

Parameters:
- H_EMPTY, 10: height below this means the tray is not germinated.
- G_PEA, 200: minimum green for the pea class.
- H_PEA, 60: minimum height for the pea class.
- G_SUN, 120: minimum green for the sunflower class.
- H_SUN, 40: minimum height for the sunflower class.
- G_PALE, 80: green below this means unhealthy.
- H_HARVEST, 50: minimum height for harvest-ready.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-high: asserted = 1. Port name kept for harness compatibility.
- ena  in  1  tile enable; when 0, all strobes and commands are ignored and state holds.
- ui_in  in  8  feature data byte.
- uio_in  in  8  control: [1:0] feature id (0=green, 1=red, 2=height, 3=ignored); [2] load strobe; [3] classify strobe; [4] clear strobe; [7:5] unused.
- uo_out  out  8  status: [2:0] class, [3] result_valid, [4] harvest_ready, [7:5] loaded flags {H,R,G}.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all uio pins are inputs).

Behaviour:
- Reset: feature registers G, R and H = 0; loaded flags = 0; class = 0; result_valid = 0; harvest_ready = 0; FSM = IDLE. All uo_out bits are 0 during and after reset.
- Load: on an edge with ena=1, uio_in[2]=1 and id≠3:
  - the selected feature register takes ui_in;
  - its loaded flag sets;
  - result_valid and harvest_ready clear;
  - class holds its previous value.
  - Reloading a feature overwrites it.
- Clear: uio_in[4]=1 with ena=1 zeroes the feature registers, loaded flags, class, valid and harvest, and returns the FSM to IDLE.
- Clear has priority over load and classify in the same cycle.
- FSM states:
  - IDLE/DONE: classify strobe → EVAL.
  - EVAL: exactly one cycle; writes class, harvest_ready and result_valid=1, then → DONE.
  - DONE behaves as IDLE; the result holds until the next load, clear, classify or reset.
  - A classify strobe while in EVAL is ignored.
- Latency: classify sampled at edge N → result visible on uo_out after edge N+1.
- A load and a classify in the same cycle: the load is stored at edge N and EVAL uses the new value.
- Classification, first matching rule wins (all comparisons are unsigned 8-bit):
  1. Any loaded flag is 0 → class 7 (INCOMPLETE).
  2. H < H_EMPTY → class 0 (EMPTY).
  3. R > G → class 1 (RADISH).
  4. G ≥ G_PEA and H ≥ H_PEA → class 2 (PEA).
  5. G ≥ G_SUN and H ≥ H_SUN → class 3 (SUNFLOWER).
  6. G < G_PALE → class 4 (UNHEALTHY).
  7. Otherwise → class 5 (GENERIC).
  - Class 6 is never produced.
- harvest_ready = 1 iff class ∈ {1, 2, 3} and H ≥ H_HARVEST.
- The loaded flags on uo_out[7:5] are live, not gated by result_valid.
- Reset asserted mid-EVAL: immediate return to the reset state; no result is produced.

Decomposition:
- Shared package holds:
  - class code constants (EMPTY=0, RADISH=1, PEA=2, SUNFLOWER=3, UNHEALTHY=4, GENERIC=5, INCOMPLETE=7);
  - feature id constants;
  - FSM state typedef (IDLE, EVAL, DONE);
  - threshold defaults.
- One sub-module, microgreen_rules: purely combinational; inputs G, R, H and the loaded flags; outputs class and harvest_ready. The top holds the registers and the FSM.

Test Plan:
- Reset → uo_out=0x00, uio_oe=0x00, uio_out=0x00. Load G only, then classify → after 2 edges uo_out=0x2F (class 7, valid).
- G=220, R=30, H=70, classify → 0xFA (PEA, harvest). Then reload H=45 → valid clears, uo_out=0xE2; classify → 0xEB (SUNFLOWER, no harvest).
- G=90, R=150, H=55 → 0xF9 (RADISH, harvest). G=60, R=50, H=30 → 0xEC (UNHEALTHY).
- Boundaries:
  - H=9 → 0xE8 (EMPTY).
  - H=10, G=100, R=20 → 0xED (GENERIC).
  - G=200, H=60, R=0 → 0xFA (PEA).
  - G=199, H=60, R=0 → 0xFB (SUNFLOWER, harvest).
- Load and classify in the same cycle with H=5 over an otherwise PEA set → 0xE8. Classify with ena=0 → no change. Clear together with classify → 0x00.
- Assert reset one cycle after classify (during EVAL) → uo_out=0x00 immediately. After deassert, loaded flags are 0 and classify yields 0x0F.

Source files
------------

// File: rtl/microgreen_classifier_pkg.sv
// Shared constants and types for the microgreen tray classifier.
package microgreen_classifier_pkg;

  // Class codes reported on uo_out[2:0]; code 6 is never produced.
  localparam logic [2:0] CLS_EMPTY      = 3'd0;
  localparam logic [2:0] CLS_RADISH     = 3'd1;
  localparam logic [2:0] CLS_PEA        = 3'd2;
  localparam logic [2:0] CLS_SUNFLOWER  = 3'd3;
  localparam logic [2:0] CLS_UNHEALTHY  = 3'd4;
  localparam logic [2:0] CLS_GENERIC    = 3'd5;
  localparam logic [2:0] CLS_INCOMPLETE = 3'd7;

  // Feature ids carried on uio_in[1:0]; id 3 selects nothing.
  localparam logic [1:0] FID_GREEN  = 2'd0;
  localparam logic [1:0] FID_RED    = 2'd1;
  localparam logic [1:0] FID_HEIGHT = 2'd2;
  localparam logic [1:0] FID_NONE   = 2'd3;

  // Rule thresholds (unsigned 8-bit).
  localparam logic [7:0] H_EMPTY   = 8'd10;
  localparam logic [7:0] G_PEA     = 8'd200;
  localparam logic [7:0] H_PEA     = 8'd60;
  localparam logic [7:0] G_SUN     = 8'd120;
  localparam logic [7:0] H_SUN     = 8'd40;
  localparam logic [7:0] G_PALE    = 8'd80;
  localparam logic [7:0] H_HARVEST = 8'd50;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/microgreen_classifier_rules.sv
// Combinational priority rule set: features and loaded flags in, class and
// harvest-ready out.
module microgreen_rules
  import microgreen_classifier_pkg::*;
(
  input  logic [7:0] g,
  input  logic [7:0] r,
  input  logic [7:0] h,
  input  logic [2:0] loaded,   // {H, R, G}
  output logic [2:0] cls,
  output logic       harvest
);

  // First matching rule wins; harvest only for crop classes that are tall enough.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    cls     = CLS_GENERIC;
    harvest = 1'b0;
    if (loaded != 3'b111)                    cls = CLS_INCOMPLETE;
    else if (h < H_EMPTY)                    cls = CLS_EMPTY;
    else if (r > g)                          cls = CLS_RADISH;
    else if (g >= G_PEA && h >= H_PEA)       cls = CLS_PEA;
    else if (g >= G_SUN && h >= H_SUN)       cls = CLS_SUNFLOWER;
    else if (g < G_PALE)                     cls = CLS_UNHEALTHY;
    else                                     cls = CLS_GENERIC;

    if ((cls == CLS_RADISH || cls == CLS_PEA || cls == CLS_SUNFLOWER) &&
        h >= H_HARVEST)
      harvest = 1'b1;
  end

endmodule

// File: rtl/microgreen_classifier.sv
// Tiny Tapeout tile top: feature registers, load/classify/clear decode and
// the IDLE/EVAL/DONE sequencer around the combinational rule set.
// rst_n is active-high despite its name; the name is fixed by the harness.
module microgreen_classifier
  import microgreen_classifier_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] g_q, r_q, h_q;
  logic [2:0] loaded_q;        // {H, R, G}
  logic [2:0] cls_q;
  logic       valid_q;
  logic       harvest_q;
  state_t     state_q, state_d;

  logic [2:0] rule_cls;
  logic       rule_harvest;

  logic [1:0] fid;
  logic       do_load, do_classify, do_clear;

  assign fid         = uio_in[1:0];
  assign do_clear    = ena & uio_in[4];
  assign do_load     = ena & uio_in[2] & (fid != FID_NONE);
  assign do_classify = ena & uio_in[3];

  microgreen_rules u_rules (
    .g       (g_q),
    .r       (r_q),
    .h       (h_q),
    .loaded  (loaded_q),
    .cls     (rule_cls),
    .harvest (rule_harvest)
  );

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_n) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: clear wins, EVAL lasts one cycle, classify ignored while in EVAL.
  always_comb begin
    state_d = state_q;
    if (do_clear) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (do_classify) state_d = ST_EVAL;
        ST_EVAL:          state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // Feature registers and result: clear first, then EVAL capture, then loads.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n || do_clear) begin
      g_q       <= '0;
      r_q       <= '0;
      h_q       <= '0;
      loaded_q  <= '0;
      cls_q     <= '0;
      valid_q   <= 1'b0;
      harvest_q <= 1'b0;
    end else begin
      if (state_q == ST_EVAL) begin
        cls_q     <= rule_cls;
        harvest_q <= rule_harvest;
        valid_q   <= 1'b1;
      end
      // A load invalidates any result, including one being captured now.
      if (do_load) begin
        case (fid)
          FID_GREEN:  g_q <= ui_in;
          FID_RED:    r_q <= ui_in;
          FID_HEIGHT: h_q <= ui_in;
          default:    ;
        endcase
        loaded_q[fid] <= 1'b1;
        valid_q       <= 1'b0;
        harvest_q     <= 1'b0;
      end
    end
  end

  assign uo_out  = {loaded_q, harvest_q, valid_q, cls_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_microgreen_classifier.sv
// Directed bench for microgreen_classifier: a vector table for the rule set
// plus hand-written sequences for latency, reload, enable, clear and reset.
module tb_microgreen_classifier;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] h;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs [14];

  microgreen_classifier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] id, input logic [7:0] v);
    ui_in  = v;
    uio_in = {5'b00000, 1'b1, id};
    tick();
    uio_in = 8'h00;
  endtask

  task automatic load_all(input logic [7:0] g, input logic [7:0] r, input logic [7:0] h);
    load(2'd0, g);
    load(2'd1, r);
    load(2'd2, h);
  endtask

  // Classify strobe for one edge, then one more edge for EVAL to write the result.
  task automatic classify();
    uio_in = 8'h08;
    tick();
    uio_in = 8'h00;
    tick();
  endtask

  task automatic clear();
    uio_in = 8'h10;
    tick();
    uio_in = 8'h00;
  endtask

  initial begin
    vecs[0]  = '{8'd220, 8'd30,  8'd70, 8'hFA, "pea"};
    vecs[1]  = '{8'd90,  8'd150, 8'd55, 8'hF9, "radish"};
    vecs[2]  = '{8'd60,  8'd50,  8'd30, 8'hEC, "unhealthy"};
    vecs[3]  = '{8'd100, 8'd20,  8'd9,  8'hE8, "empty_h9"};
    vecs[4]  = '{8'd100, 8'd20,  8'd10, 8'hED, "generic_h10"};
    vecs[5]  = '{8'd200, 8'd0,   8'd60, 8'hFA, "pea_edge"};
    vecs[6]  = '{8'd199, 8'd0,   8'd60, 8'hFB, "sun_g199"};
    vecs[7]  = '{8'd200, 8'd0,   8'd59, 8'hFB, "sun_h59"};
    vecs[8]  = '{8'd150, 8'd0,   8'd50, 8'hFB, "sun_harv50"};
    vecs[9]  = '{8'd150, 8'd0,   8'd49, 8'hEB, "sun_h49"};
    vecs[10] = '{8'd119, 8'd0,   8'd45, 8'hED, "generic_g119"};
    vecs[11] = '{8'd100, 8'd100, 8'd30, 8'hED, "r_eq_g"};
    vecs[12] = '{8'd80,  8'd0,   8'd20, 8'hED, "generic_g80"};
    vecs[13] = '{8'd79,  8'd0,   8'd20, 8'hEC, "pale_g79"};

    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b1;
    repeat (2) tick();
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    rst_n = 1'b0;
    tick();
    check("after_reset", uo_out, 8'h00);

    // Incomplete set plus latency: nothing visible after the classify edge alone.
    load(2'd0, 8'd50);
    check("g_loaded_flag", uo_out, 8'h20);
    uio_in = 8'h08;
    tick();
    uio_in = 8'h00;
    check("eval_not_yet_valid", uo_out, 8'h20);
    tick();
    check("incomplete", uo_out, 8'h2F);
    clear();
    check("clear_all", uo_out, 8'h00);

    // Rule table.
    for (int i = 0; i < 14; i++) begin
      load_all(vecs[i].g, vecs[i].r, vecs[i].h);
      check({vecs[i].name, "_loaded_not_valid"}, uo_out & 8'hF8, 8'hE0);
      classify();
      check(vecs[i].name, uo_out, vecs[i].exp);
    end

    // Reloading height invalidates the result but keeps the class code.
    load_all(8'd220, 8'd30, 8'd70);
    classify();
    check("reload_pea", uo_out, 8'hFA);
    load(2'd2, 8'd45);
    check("reload_invalidates", uo_out, 8'hE2);
    classify();
    check("reload_sunflower", uo_out, 8'hEB);

    // Load and classify on the same edge: EVAL sees the new height.
    load(2'd2, 8'd70);
    ui_in  = 8'd5;
    uio_in = 8'h0E;
    tick();
    uio_in = 8'h00;
    tick();
    check("load_with_classify", uo_out, 8'hE8);

    // ena low: strobes ignored.
    ena    = 1'b0;
    ui_in  = 8'd70;
    uio_in = 8'h0E;
    repeat (2) tick();
    check("ena_low_hold", uo_out, 8'hE8);
    uio_in = 8'h10;
    tick();
    check("ena_low_no_clear", uo_out, 8'hE8);
    uio_in = 8'h00;
    ena    = 1'b1;

    // Clear beats classify and load in the same cycle.
    uio_in = 8'h18;
    tick();
    check("clear_with_classify", uo_out, 8'h00);
    uio_in = 8'h00;
    tick();
    check("clear_no_eval", uo_out, 8'h00);
    ui_in  = 8'd99;
    uio_in = 8'h14;
    tick();
    uio_in = 8'h00;
    check("clear_beats_load", uo_out, 8'h00);

    // Id 3 loads nothing.
    ui_in  = 8'd99;
    uio_in = 8'h07;
    tick();
    uio_in = 8'h00;
    check("id3_ignored", uo_out, 8'h00);

    // Reset asserted during EVAL: immediate return to reset state.
    load_all(8'd220, 8'd30, 8'd70);
    uio_in = 8'h08;
    tick();
    uio_in = 8'h00;
    #1 rst_n = 1'b1;
    #1 check("reset_mid_eval", uo_out, 8'h00);
    tick();
    rst_n = 1'b0;
    tick();
    check("after_mid_eval_reset", uo_out, 8'h00);
    classify();
    check("post_reset_incomplete", uo_out, 8'h0F);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
